// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad command decoder: button indices, command codes,
// FSM state type and parameter defaults.
package joypad_pkg;

    localparam int NUM_BUTTONS = 11;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;

    localparam int HOLD_FRAMES_DEF   = 20;
    localparam int REPEAT_FRAMES_DEF = 6;
    localparam int FIFO_DEPTH_DEF    = 4;

    typedef enum logic [2:0] {
        CMD_UP    = 3'd0,
        CMD_DOWN  = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_ACT_A = 3'd4,
        CMD_ACT_B = 3'd5,
        CMD_ACT_C = 3'd6,
        CMD_START = 3'd7
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small show-ahead command queue; a push on a full queue succeeds only when a pop
// happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/joypad_cmd_decoder.sv
// Frame-paced joypad decoder: latches buttons on each vsync edge, scans 8 command
// slots and queues press-edge commands. Optional auto-repeat via AUTO_REPEAT_EN.
module joypad_cmd_decoder
    import joypad_pkg::*;
#(
    parameter int HOLD_FRAMES   = HOLD_FRAMES_DEF,
    parameter int REPEAT_FRAMES = REPEAT_FRAMES_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    input  logic                   vga_vs,
    input  logic                   cmd_ready,
    output logic                   cmd_valid,
    output logic [2:0]             cmd_code,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   overflow
);

    logic [2:0]             vs_sync_reg;
    logic                   tick_reg;
    state_e                 state_reg;
    state_e                 state_next;
    logic [2:0]             slot_reg;
    logic [NUM_BUTTONS-1:0] held_reg;
    logic [NUM_BUTTONS-1:0] prev_reg;
    logic                   overflow_reg;

    logic [NUM_BUTTONS-1:0] new_press;
    logic                   ud_block;
    logic                   lr_block;
    logic [3:0]             rep_dir;
    logic [3:0]             dir_cand;
    logic [3:0]             dir_sel;
    logic [7:0]             slot_hit;
    logic                   push;
    cmd_e                   push_cmd;
    logic                   pop;
    logic [2:0]             head;
    logic                   full;
    logic                   empty;

    // Two flops synchronise vsync, the third remembers the last synchronised level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_sync_reg <= '0;
            tick_reg    <= 1'b0;
        end else begin
            vs_sync_reg <= {vs_sync_reg[1:0], vga_vs};
            tick_reg    <= vs_sync_reg[1] & ~vs_sync_reg[2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            slot_reg  <= '0;
            held_reg  <= '0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= (state_reg == ST_SCAN) ? slot_reg + 3'd1 : 3'd0;
            if (state_reg == ST_IDLE && tick_reg) begin
                held_reg <= buttons_in;
                prev_reg <= held_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (tick_reg) state_next = ST_SCAN;
            ST_SCAN: if (slot_reg == 3'd7) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0;
        if (state_reg == ST_SCAN) push = slot_hit[slot_reg];
    end

    assign new_press = held_reg & ~prev_reg;
    assign ud_block  = held_reg[BTN_UP]   & held_reg[BTN_DOWN];
    assign lr_block  = held_reg[BTN_LEFT] & held_reg[BTN_RIGHT];

`ifdef AUTO_REPEAT_EN
    localparam int CW = $clog2(HOLD_FRAMES + 1);

    logic [CW-1:0] rep_cnt_reg;
    logic [CW-1:0] rep_cnt_eff;
    logic          same_dir;
    logic          rep_fire;

    // rep_cnt_eff is the number of frames since the direction was first pressed.
    assign same_dir    = one_hot4(held_reg[3:0]) && (held_reg[3:0] == prev_reg[3:0]);
    assign rep_cnt_eff = same_dir ? rep_cnt_reg + 1'b1 : '0;
    assign rep_fire    = same_dir && (rep_cnt_eff == CW'(HOLD_FRAMES));
    assign rep_dir     = rep_fire ? held_reg[3:0] : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_reg <= '0;
        end else if (state_reg == ST_SCAN && slot_reg == 3'd7) begin
            rep_cnt_reg <= rep_fire ? CW'(HOLD_FRAMES - REPEAT_FRAMES) : rep_cnt_eff;
        end
    end
`else
    assign rep_dir = 4'b0000;
`endif

    assign dir_cand = {new_press[BTN_RIGHT] & ~lr_block,
                       new_press[BTN_LEFT]  & ~lr_block,
                       new_press[BTN_DOWN]  & ~ud_block,
                       new_press[BTN_UP]    & ~ud_block} | rep_dir;
    // Isolate the lowest set bit: UP beats DOWN beats LEFT beats RIGHT.
    assign dir_sel  = dir_cand & (~dir_cand + 4'd1);
    assign slot_hit = {new_press[BTN_START], new_press[BTN_C],
                       new_press[BTN_B], new_press[BTN_A], dir_sel};
    assign push_cmd = cmd_e'(slot_reg);

    assign cmd_valid = ~empty;
    assign pop       = cmd_valid & cmd_ready;

    cmd_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (push && full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign cmd_code = cmd_valid ? head : 3'd0;
    assign held     = held_reg;
    assign overflow = overflow_reg;

endmodule
